// File: rtl/divu_sequencer.sv
// Multi-cycle unsigned divide controller that owns HI/LO. Restoring shift-subtract
// divider, one quotient bit per cycle, with pipeline stall generation.
module divu_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             hilo_rd,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             zflag_q, dz_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_d, quo_d;

  // The shift keeps rem's MSB so divisors with the top bit set still divide correctly.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dsr_q};
    fits    = ~trial[WIDTH];
    rem_d   = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      zflag_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start && !flush) begin
            rem_q   <= '0;
            quo_q   <= dividend;
            dsr_q   <= divisor;
            cnt_q   <= CNT_W'(WIDTH);
            zflag_q <= (divisor == '0);
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          if (flush) begin
            state_q <= StIdle;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              hi_q    <= rem_d;
              lo_q    <= quo_d;
              dz_q    <= zflag_q;
              state_q <= StDone;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign stall    = busy & (start | hilo_rd);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_divu_sequencer.sv
// Scoreboard bench for divu_sequencer: driver pushes expected results from a plain
// arithmetic model, a monitor pops and compares on every done pulse.
module tb_divu_sequencer;

  localparam int W = 32;

  logic          clk, rst, start, hilo_rd, flush;
  logic [W-1:0]  dividend, divisor;
  logic          stall, busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_count = 0;

  divu_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .hilo_rd  (hilo_rd),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int c);
    exp_t e;
    if (b == '0) begin
      e.lo = '1;
      e.hi = a;
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    e.dz  = (b == '0);
    e.cyc = c;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_count++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1, expected no pending divide (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("lo", lo, mon_e.lo);
        chk("hi", hi, mon_e.hi);
        chkb("div_zero", div_zero, mon_e.dz);
        chk("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Holds start until accepted (IDLE or DONE); acc is the cycle count just before accept.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
    int guard = 0;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    while (busy && guard < 200) begin
      #1 chkb("stall_hold", stall, 1'b1);
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got busy=1, expected accept within 200 cycles");
    end
    acc = cyc;
    exp_q.push_back(model(a, b, cyc + W + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy || done) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy || done) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: got busy=%b done=%b, expected idle", busy, done);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, nb, gap;
    logic [W-1:0] h0, l0, a, b;
    logic be;

    rst = 1'b1; start = 1'b1; hilo_rd = 1'b1; flush = 1'b0;
    dividend = 32'd5; divisor = 32'd1;
    #3;
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_done", done, 1'b0);
    chkb("rst_dz", div_zero, 1'b0);
    chkb("rst_stall", stall, 1'b0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0; hilo_rd = 1'b0;

    // 100 / 7: busy exactly W cycles
    issue(32'd100, 32'd7, acc1);
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    chk("busy_cycles", nb, W);
    #1 chkb("done_after_run", done, 1'b1);

    // Back-to-back: second accept must land on the first DONE cycle
    issue(32'hFFFF_FFFF, 32'd1, acc1);
    issue(32'h1234_5678, 32'h10, acc2);
    chk("b2b_accept", acc2, acc1 + W + 1);
    wait_idle();

    issue(32'hDEAD_BEEF, 32'd0, acc1);
    wait_idle();
    chkb("dz_set", div_zero, 1'b1);
    issue(32'd9, 32'd3, acc1);
    wait_idle();
    chkb("dz_clear", div_zero, 1'b0);

    // Pending mfhi/mflo stalls until the DONE cycle
    issue(32'd1000, 32'd3, acc1);
    repeat (4) @(negedge clk);
    hilo_rd = 1'b1;
    nb = 0;
    while (busy && nb < 100) begin
      #1 chkb("hilo_stall", stall, 1'b1);
      @(negedge clk);
      nb++;
    end
    #1;
    chkb("hilo_stall_drop", stall, 1'b0);
    chkb("hilo_done", done, 1'b1);
    chk("hilo_lo_now", lo, 32'd333);
    hilo_rd = 1'b0;
    wait_idle();
    hilo_rd = 1'b1;
    #1 chkb("hilo_idle_stall", stall, 1'b0);
    hilo_rd = 1'b0;

    // Flush at RUN cycle 10 discards the divide
    h0 = hi; l0 = lo; nb = done_count;
    @(negedge clk);
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chkb("flush_idle", busy, 1'b0);
    chkb("flush_nodone", done, 1'b0);
    repeat (40) @(negedge clk);
    chk("flush_done_count", done_count, nb);
    chk("flush_hi", hi, h0);
    chk("flush_lo", lo, l0);
    flush = 1'b1; start = 1'b1;
    @(negedge clk);
    #1 chkb("flush_start_busy", busy, 1'b0);
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    chkb("flush_start_busy2", busy, 1'b0);

    // Randomized divides with random gaps and mfhi/mflo traffic
    for (int i = 0; i < 24; i++) begin
      a = $urandom();
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 20));
        3:       b = $urandom() | 32'h8000_0000;
        default: b = $urandom() >> $urandom_range(0, 31);
      endcase
      issue(a, b, acc1);
      gap = $urandom_range(0, 4);
      repeat (gap) begin
        @(negedge clk);
        hilo_rd = 1'($urandom_range(0, 1));
        be = (cyc > acc1) && (cyc < acc1 + W + 1);
        #1;
        chkb("rand_busy", busy, be);
        chkb("rand_stall", stall, be & hilo_rd);
      end
      hilo_rd = 1'b0;
    end
    wait_idle();

    // Async reset mid-RUN clears everything before the next edge
    issue(32'd100, 32'd7, acc1);
    wait_idle();
    @(negedge clk);
    start = 1'b1; dividend = 32'd77; divisor = 32'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    hilo_rd = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_hi", hi, '0);
    chk("arst_lo", lo, '0);
    chkb("arst_busy", busy, 1'b0);
    chkb("arst_done", done, 1'b0);
    chkb("arst_stall", stall, 1'b0);
    chkb("arst_dz", div_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0; hilo_rd = 1'b0;
    repeat (40) @(negedge clk);
    chk("arst_hi_after", hi, '0);

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
